simulador_drone: RTL and testbench



---
 rtl/drone_pkg.sv | 61 ++++++
 rtl/hexa7seg.sv | 36 +++
 rtl/simulador_drone.sv | 178 +++++++++++++++++
 tb/tb_simulador_drone.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/drone_pkg.sv
// Shared definitions for the drone-obstacle game: grid limits, FSM state
// codes, difficulty modes and the per-mode obstacle map.
package drone_pkg;

  localparam int unsigned LARGURA   = 16;  // grid columns
  localparam int unsigned ALTURA    = 4;   // grid rows
  localparam int unsigned MAX_VIDAS = 3;

  localparam int unsigned HW = 4;  // column index width
  localparam int unsigned VW = 2;  // row index width
  localparam int unsigned LW = 2;  // lives width
  localparam int unsigned CW = 4;  // collision counter width

  localparam logic [HW-1:0] H_MAX = 4'(LARGURA - 1);
  localparam logic [VW-1:0] V_MAX = 2'(ALTURA - 1);
  localparam logic [LW-1:0] L_MAX = 2'(MAX_VIDAS);
  localparam logic [CW-1:0] C_MAX = 4'hF;

  // Codes are shown on the state display, so they are fixed values.
  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    ESCOLHE_MODO  = 4'h1,
    ESCOLHE_VIDAS = 4'h2,
    JOGANDO       = 4'h3,
    VERIFICA      = 4'h4,
    COLISAO       = 4'h5,
    VENCEU        = 4'hA,
    PERDEU        = 4'hF
  } estado_t;

  typedef enum logic [1:0] {
    MODO_NENHUM  = 2'b00,
    MODO_FACIL   = 2'b01,
    MODO_DIFICIL = 2'b10
  } modo_t;

  // Obstacle mask of one column; bit r blocks row r.
  function automatic logic [3:0] obstaculo(input modo_t modo, input logic [HW-1:0] coluna);
    logic [3:0] mascara;
    mascara = 4'b0000;
    if (modo == MODO_FACIL) begin
      case (coluna)
        4'd4:    mascara = 4'b0001;
        4'd8:    mascara = 4'b0010;
        4'd12:   mascara = 4'b0100;
        default: mascara = 4'b0000;
      endcase
    end else if (modo == MODO_DIFICIL) begin
      case (coluna)
        4'd3:    mascara = 4'b0011;
        4'd6:    mascara = 4'b0110;
        4'd9:    mascara = 4'b1100;
        4'd12:   mascara = 4'b0011;
        4'd14:   mascara = 4'b0110;
        default: mascara = 4'b0000;
      endcase
    end
    return mascara;
  endfunction

endpackage

// File: rtl/hexa7seg.sv
// Hex digit to 7-segment decoder.
// valor      : 4-bit value
// segmentos_c: active-low segments, bit0 = a ... bit6 = g
module hexa7seg (
  input  logic [3:0] valor,
  output logic [6:0] segmentos_c
);

  logic [6:0] ativo;

  // Active-high glyph table, inverted at the output.
  always_comb begin
    ativo = 7'h00;
    case (valor)
      4'h0: ativo = 7'h3F;
      4'h1: ativo = 7'h06;
      4'h2: ativo = 7'h5B;
      4'h3: ativo = 7'h4F;
      4'h4: ativo = 7'h66;
      4'h5: ativo = 7'h6D;
      4'h6: ativo = 7'h7D;
      4'h7: ativo = 7'h07;
      4'h8: ativo = 7'h7F;
      4'h9: ativo = 7'h6F;
      4'hA: ativo = 7'h77;
      4'hB: ativo = 7'h7C;
      4'hC: ativo = 7'h39;
      4'hD: ativo = 7'h5E;
      4'hE: ativo = 7'h79;
      4'hF: ativo = 7'h71;
      default: ativo = 7'h00;
    endcase
    segmentos_c = ~ativo;
  end

endmodule

// File: rtl/simulador_drone.sv
// Drone-obstacle game controller: menu for mode and lives, then moves a
// drone on a 16x4 grid, counting collisions until it wins or loses.
// clock, reset (sync, active-low); iniciar, confirma, controle_vertical,
// controle_horizontal: player inputs (acted on at their rising change).
// venceu/perdeu: end-of-game flags; db_*: 7-seg debug displays;
// db_modo: chosen mode; colisao_counter_out: 7-seg collision count.
module simulador_drone (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] controle_vertical,
  input  logic [1:0] controle_horizontal,
  input  logic       confirma,
  output logic       venceu,
  output logic       perdeu,
  output logic [6:0] db_posicao_horizontal,
  output logic [6:0] db_posicao_vertical,
  output logic [6:0] db_obstaculos,
  output logic [6:0] db_estado,
  output logic [1:0] db_modo,
  output logic [6:0] colisao_counter_out,
  output logic [6:0] db_vidas
);

  import drone_pkg::*;

  estado_t       estado, estado_prox;
  modo_t         modo, modo_prox;
  logic [HW-1:0] h, h_prox, h_cand, h_cand_prox;
  logic [VW-1:0] v, v_prox, v_cand, v_cand_prox;
  logic [LW-1:0] vidas, vidas_prox;
  logic [CW-1:0] colisoes, colisoes_prox;

  logic       iniciar_ant, confirma_ant;
  logic [1:0] vertical_ant, horizontal_ant;

  // Actions fire only on the cycle an input changes into its active value.
  logic borda_iniciar, borda_confirma, borda_cima, borda_baixo, borda_frente, borda_tras;
  assign borda_iniciar  = iniciar & ~iniciar_ant;
  assign borda_confirma = confirma & ~confirma_ant;
  assign borda_cima     = (controle_vertical == 2'b01) && (vertical_ant != 2'b01);
  assign borda_baixo    = (controle_vertical == 2'b10) && (vertical_ant != 2'b10);
  assign borda_frente   = (controle_horizontal == 2'b01) && (horizontal_ant != 2'b01);
  assign borda_tras     = (controle_horizontal == 2'b10) && (horizontal_ant != 2'b10);

  logic [3:0] mascara_cand;
  assign mascara_cand = obstaculo(modo, h_cand);

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado         <= INICIAL;
      modo           <= MODO_NENHUM;
      h              <= '0;
      v              <= '0;
      h_cand         <= '0;
      v_cand         <= '0;
      vidas          <= '0;
      colisoes       <= '0;
      iniciar_ant    <= 1'b0;
      confirma_ant   <= 1'b0;
      vertical_ant   <= 2'b00;
      horizontal_ant <= 2'b00;
    end else begin
      estado         <= estado_prox;
      modo           <= modo_prox;
      h              <= h_prox;
      v              <= v_prox;
      h_cand         <= h_cand_prox;
      v_cand         <= v_cand_prox;
      vidas          <= vidas_prox;
      colisoes       <= colisoes_prox;
      iniciar_ant    <= iniciar;
      confirma_ant   <= confirma;
      vertical_ant   <= controle_vertical;
      horizontal_ant <= controle_horizontal;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    estado_prox   = estado;
    modo_prox     = modo;
    h_prox        = h;
    v_prox        = v;
    h_cand_prox   = h_cand;
    v_cand_prox   = v_cand;
    vidas_prox    = vidas;
    colisoes_prox = colisoes;

    case (estado)
      INICIAL: begin
        h_prox        = '0;
        v_prox        = '0;
        vidas_prox    = '0;
        colisoes_prox = '0;
        modo_prox     = MODO_NENHUM;
        if (borda_iniciar) begin
          estado_prox = ESCOLHE_MODO;
          modo_prox   = MODO_FACIL;
        end
      end
      ESCOLHE_MODO: begin
        if (borda_confirma) begin
          estado_prox = ESCOLHE_VIDAS;
          vidas_prox  = 2'd1;
        end else if (borda_cima) begin
          modo_prox = MODO_DIFICIL;
        end else if (borda_baixo) begin
          modo_prox = MODO_FACIL;
        end
      end
      ESCOLHE_VIDAS: begin
        if (borda_confirma) begin
          estado_prox   = JOGANDO;
          h_prox        = '0;
          v_prox        = '0;
          colisoes_prox = '0;
        end else if (borda_cima && (vidas != L_MAX)) begin
          vidas_prox = vidas + 2'd1;
        end else if (borda_baixo && (vidas > 2'd1)) begin
          vidas_prox = vidas - 2'd1;
        end
      end
      JOGANDO: begin
        // Horizontal wins when both axes change in the same cycle.
        if (borda_frente || borda_tras) begin
          estado_prox = VERIFICA;
          v_cand_prox = v;
          if (borda_frente) h_cand_prox = (h == H_MAX) ? H_MAX : h + 4'd1;
          else              h_cand_prox = (h == '0) ? h : h - 4'd1;
        end else if (borda_cima || borda_baixo) begin
          estado_prox = VERIFICA;
          h_cand_prox = h;
          if (borda_cima) v_cand_prox = (v == V_MAX) ? V_MAX : v + 2'd1;
          else            v_cand_prox = (v == '0) ? v : v - 2'd1;
        end
      end
      VERIFICA: begin
        if (mascara_cand[v_cand]) begin
          estado_prox = COLISAO;
        end else begin
          h_prox      = h_cand;
          v_prox      = v_cand;
          estado_prox = (h_cand == H_MAX) ? VENCEU : JOGANDO;
        end
      end
      COLISAO: begin
        vidas_prox    = vidas - 2'd1;
        colisoes_prox = (colisoes == C_MAX) ? C_MAX : colisoes + 4'd1;
        estado_prox   = (vidas == 2'd1) ? PERDEU : JOGANDO;
      end
      VENCEU, PERDEU: begin
        if (borda_iniciar) begin
          estado_prox = ESCOLHE_MODO;
          modo_prox   = MODO_FACIL;
        end
      end
      default: estado_prox = INICIAL;
    endcase
  end

  assign venceu  = (estado == VENCEU);
  assign perdeu  = (estado == PERDEU);
  assign db_modo = modo;

  // Obstacles ahead of the drone; nothing lies beyond the last column.
  logic [3:0] mascara_frente;
  assign mascara_frente = (h == H_MAX) ? 4'b0000 : obstaculo(modo, h + 4'd1);

  hexa7seg u_hex_h      (.valor(h),                   .segmentos_c(db_posicao_horizontal));
  hexa7seg u_hex_v      (.valor({2'b00, v}),          .segmentos_c(db_posicao_vertical));
  hexa7seg u_hex_obs    (.valor(mascara_frente),      .segmentos_c(db_obstaculos));
  hexa7seg u_hex_estado (.valor(4'(estado)),          .segmentos_c(db_estado));
  hexa7seg u_hex_col    (.valor(colisoes),            .segmentos_c(colisao_counter_out));
  hexa7seg u_hex_vidas  (.valor({2'b00, vidas}),      .segmentos_c(db_vidas));

endmodule

// File: tb/tb_simulador_drone.sv
// Scoreboard bench for simulador_drone: actions update a game-level model,
// expected per-cycle snapshots are queued and a monitor compares them.
module tb_simulador_drone;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, confirma;
  logic [1:0] controle_vertical, controle_horizontal;
  logic       venceu, perdeu;
  logic [6:0] db_posicao_horizontal, db_posicao_vertical, db_obstaculos;
  logic [6:0] db_estado, colisao_counter_out, db_vidas;
  logic [1:0] db_modo;

  simulador_drone dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .controle_vertical(controle_vertical), .controle_horizontal(controle_horizontal),
    .confirma(confirma), .venceu(venceu), .perdeu(perdeu),
    .db_posicao_horizontal(db_posicao_horizontal), .db_posicao_vertical(db_posicao_vertical),
    .db_obstaculos(db_obstaculos), .db_estado(db_estado), .db_modo(db_modo),
    .colisao_counter_out(colisao_counter_out), .db_vidas(db_vidas)
  );

  always #5 clock = ~clock;

  typedef struct {
    int st; int h; int v; int lives; int cnt; int mode;
  } snap_t;

  snap_t exp_q[$];
  snap_t m;        // model of the game as the player sees it
  snap_t e_mon;
  int tests = 0;
  int fails = 0;

  function automatic int obst(input int mode, input int col);
    if (mode == 1) begin
      if (col == 4) return 1;
      if (col == 8) return 2;
      if (col == 12) return 4;
    end else if (mode == 2) begin
      if (col == 3) return 3;
      if (col == 6) return 6;
      if (col == 9) return 12;
      if (col == 12) return 3;
      if (col == 14) return 6;
    end
    return 0;
  endfunction

  // Active-low glyphs, bit0 = a.
  function automatic int seg(input int val);
    case (val)
      0: return 'h40;  1: return 'h79;  2: return 'h24;  3: return 'h30;
      4: return 'h19;  5: return 'h12;  6: return 'h02;  7: return 'h78;
      8: return 'h00;  9: return 'h10; 10: return 'h08; 11: return 'h03;
      12: return 'h46; 13: return 'h21; 14: return 'h06; 15: return 'h0E;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      chk("estado", int'(db_estado), seg(e_mon.st));
      chk("venceu", int'(venceu), (e_mon.st == 10) ? 1 : 0);
      chk("perdeu", int'(perdeu), (e_mon.st == 15) ? 1 : 0);
      chk("modo", int'(db_modo), e_mon.mode);
      chk("pos_h", int'(db_posicao_horizontal), seg(e_mon.h));
      chk("pos_v", int'(db_posicao_vertical), seg(e_mon.v));
      chk("vidas", int'(db_vidas), seg(e_mon.lives));
      chk("colisoes", int'(colisao_counter_out), seg(e_mon.cnt));
      chk("obstaculos", int'(db_obstaculos),
          seg((e_mon.h == 15) ? 0 : obst(e_mon.mode, e_mon.h + 1)));
    end
  end

  task automatic drive(input logic i, input logic c, input logic [1:0] vv, input logic [1:0] hh);
    iniciar = i;
    confirma = c;
    controle_vertical = vv;
    controle_horizontal = hh;
  endtask

  task automatic do_reset(input int n);
    @(posedge clock); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 2'b00);
    m = '{0, 0, 0, 0, 0, 0};
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      exp_q.push_back(m);
    end
    reset = 1'b1;
  endtask

  // One player action: inputs held for 'hold' cycles (1..5), expected
  // outputs queued for the action cycle and the five cycles after it.
  task automatic act(input logic i, input logic c, input logic [1:0] vv,
                     input logic [1:0] hh, input int hold);
    snap_t seq[$];
    snap_t s;
    int hn, vn;
    bit mv;
    @(posedge clock); #1;
    drive(i, c, vv, hh);
    exp_q.push_back(m);
    s = m;
    mv = 1'b0;
    hn = m.h;
    vn = m.v;
    case (m.st)
      0, 10, 15: if (i) begin s.st = 1; s.mode = 1; seq.push_back(s); end
      1: begin
        if (c) begin s.st = 2; s.lives = 1; seq.push_back(s); end
        else if (vv == 2'b01) begin s.mode = 2; seq.push_back(s); end
        else if (vv == 2'b10) begin s.mode = 1; seq.push_back(s); end
      end
      2: begin
        if (c) begin s.st = 3; s.h = 0; s.v = 0; s.cnt = 0; seq.push_back(s); end
        else if (vv == 2'b01) begin s.lives = (m.lives < 3) ? m.lives + 1 : 3; seq.push_back(s); end
        else if (vv == 2'b10) begin s.lives = (m.lives > 1) ? m.lives - 1 : 1; seq.push_back(s); end
      end
      3: begin
        if (hh == 2'b01 || hh == 2'b10) begin
          mv = 1'b1;
          hn = (hh == 2'b01) ? ((m.h < 15) ? m.h + 1 : 15) : ((m.h > 0) ? m.h - 1 : 0);
        end else if (vv == 2'b01 || vv == 2'b10) begin
          mv = 1'b1;
          vn = (vv == 2'b01) ? ((m.v < 3) ? m.v + 1 : 3) : ((m.v > 0) ? m.v - 1 : 0);
        end
        if (mv) begin
          s.st = 4;
          seq.push_back(s);
          if (((obst(m.mode, hn) >> vn) & 1) == 1) begin
            s.st = 5;
            seq.push_back(s);
            s.lives = m.lives - 1;
            s.cnt = (m.cnt < 15) ? m.cnt + 1 : 15;
            s.st = (s.lives == 0) ? 15 : 3;
            seq.push_back(s);
          end else begin
            s.h = hn;
            s.v = vn;
            s.st = (hn == 15) ? 10 : 3;
            seq.push_back(s);
          end
        end
      end
      default: ;
    endcase
    if (seq.size() == 0) seq.push_back(m);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      if (k + 1 == hold) drive(1'b0, 1'b0, 2'b00, 2'b00);
      exp_q.push_back(seq[(k < seq.size()) ? k : seq.size() - 1]);
    end
    m = seq[seq.size() - 1];
  endtask

  task automatic pulse_v(input logic [1:0] vv); act(1'b0, 1'b0, vv, 2'b00, 1); endtask
  task automatic pulse_h(input logic [1:0] hh); act(1'b0, 1'b0, 2'b00, hh, 1); endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 2'b00);
    do_reset(10);

    // Menu: easy mode, lives limits
    act(1'b1, 1'b0, 2'b00, 2'b00, 1);
    act(1'b0, 1'b1, 2'b00, 2'b00, 1);
    pulse_v(2'b10);
    for (int k = 0; k < 4; k++) pulse_v(2'b01);
    act(1'b0, 1'b1, 2'b00, 2'b00, 3);

    // Moves, a held input, then three collisions at column 4 row 0
    pulse_h(2'b01); pulse_v(2'b01); pulse_h(2'b01);
    act(1'b0, 1'b0, 2'b00, 2'b01, 5);
    pulse_h(2'b10); pulse_v(2'b10); pulse_h(2'b01);
    for (int k = 0; k < 3; k++) pulse_h(2'b01);
    pulse_h(2'b01);

    // Hard then back to easy, three lives, saturated moves, run along row 3
    act(1'b1, 1'b0, 2'b00, 2'b00, 1);
    pulse_v(2'b01); pulse_v(2'b10);
    act(1'b0, 1'b1, 2'b00, 2'b00, 1);
    pulse_v(2'b01); pulse_v(2'b01);
    act(1'b0, 1'b1, 2'b00, 2'b00, 1);
    pulse_v(2'b10); pulse_h(2'b10);
    for (int k = 0; k < 5; k++) pulse_v(2'b01);
    for (int k = 0; k < 15; k++) act(1'b0, 1'b0, 2'b00, 2'b01, 1 + int'($urandom_range(0, 3)));
    pulse_h(2'b10); pulse_v(2'b10);

    // Randomized games
    for (int g = 0; g < 10; g++) begin
      if (!(m.st == 0 || m.st == 10 || m.st == 15)) do_reset(2);
      act(1'b1, 1'b0, 2'b00, 2'b00, 1);
      if ($urandom_range(0, 1) == 1) pulse_v(2'b01);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        pulse_v(($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
      act(1'b0, 1'b1, 2'b00, 2'b00, 1);
      for (int k = 0; k < int'($urandom_range(0, 5)); k++)
        pulse_v(($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
      act(1'b0, 1'b1, 2'b00, 2'b00, 1);
      for (int mv = 0; mv < 60 && m.st == 3; mv++) begin
        int r;
        logic [1:0] hh, vv;
        r  = int'($urandom_range(0, 9));
        hh = (r < 5) ? 2'b01 : (r < 6) ? 2'b10 : (r < 7) ? 2'b11 : 2'b00;
        vv = 2'($urandom_range(0, 3));
        if (g == 4 && mv == 10) begin
          do_reset(2);
          break;
        end
        act(1'b0, 1'b0, vv, hh, 1 + int'($urandom_range(0, 4)));
      end
    end

    repeat (3) @(posedge clock);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
